// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch pattern-history-table controller.
// Index fields are held at a fixed maximum width; users truncate to their own IDX_W.
package branch_pkg;

    localparam int unsigned PHT_IDX_W_MAX = 16;
    localparam logic [1:0]  PHT_WEAK_NT   = 2'b01;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } pht_state_e;

    typedef struct packed {
        logic [PHT_IDX_W_MAX-1:0] idx;
        logic                     taken;
    } upd_msg_t;

    function automatic logic [1:0] sat_ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

    function automatic logic [PHT_IDX_W_MAX-1:0] pc_to_idx(input logic [31:0] pc);
        return pc[PHT_IDX_W_MAX+1:2];
    endfunction

endpackage

// File: rtl/branch_upd_queue.sv
// Small in-order FIFO of resolved-branch updates awaiting a PHT write slot.
module branch_upd_queue
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     enq_val,
    output logic     enq_rdy,
    input  upd_msg_t enq_msg,
    output logic     deq_val,
    input  logic     deq_rdy,
    output upd_msg_t deq_msg,
    output logic     full,
    output logic     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    upd_msg_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             enq_fire;
    logic             deq_fire;

    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign empty    = (count == '0);
    assign enq_rdy  = !full;
    assign deq_val  = !empty;
    assign deq_msg  = mem[rd_ptr];
    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_rdy && deq_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                mem[wr_ptr] <= enq_msg;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (PTR_W+1)'(enq_fire) - (PTR_W+1)'(deq_fire);
        end
    end

endmodule

// File: rtl/branch_pht_ctrl.sv
// Single-port PHT controller: initializes the table, then arbitrates the port
// between fetch lookups and queued read-modify-write updates with a starvation bound.
module branch_pht_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned PHT_SIZE   = 2048,
    parameter int unsigned IDX_W      = $clog2(PHT_SIZE),
    parameter int unsigned UPD_DEPTH  = 4,
    parameter int unsigned STARVE_LIM = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_req_val,
    output logic             pred_req_rdy,
    input  logic [31:0]      pred_req_pc,
    output logic             pred_resp_val,
    output logic             pred_resp_taken,
    input  logic             upd_val,
    output logic             upd_rdy,
    input  logic [31:0]      upd_pc,
    input  logic             upd_taken,
    output logic [IDX_W-1:0] tbl_idx,
    output logic             tbl_wen,
    output logic [1:0]       tbl_wdata,
    input  logic [1:0]       tbl_rdata,
    output logic             init_done
);

    localparam int unsigned SC_W = $clog2(STARVE_LIM) + 1;

    pht_state_e       state;
    pht_state_e       state_nxt;
    logic [IDX_W-1:0] init_cnt;
    logic [SC_W-1:0]  starve_cnt;
    logic [IDX_W-1:0] req_idx;
    upd_msg_t         enq_msg;
    upd_msg_t         deq_msg;
    logic             q_enq_rdy;
    logic             q_deq_val;
    logic             q_full;
    logic             q_empty;
    logic             forced;
    logic             lookup;
    logic             drain;

    assign req_idx = IDX_W'(pc_to_idx(pred_req_pc));
    assign enq_msg = '{idx: pc_to_idx(upd_pc), taken: upd_taken};

    branch_upd_queue #(.DEPTH(UPD_DEPTH)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (upd_val && upd_rdy),
        .enq_rdy (q_enq_rdy),
        .enq_msg (enq_msg),
        .deq_val (q_deq_val),
        .deq_rdy (drain),
        .deq_msg (deq_msg),
        .full    (q_full),
        .empty   (q_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt == IDX_W'(PHT_SIZE - 1)) begin
            state_nxt = ST_RUN;
        end
    end

    // Reset suppresses all port activity so a mid-drain reset never writes the table.
    always_comb begin
        forced       = 1'b0;
        lookup       = 1'b0;
        drain        = 1'b0;
        pred_req_rdy = 1'b0;
        upd_rdy      = 1'b0;
        tbl_wen      = 1'b0;
        tbl_idx      = '0;
        if (!reset) begin
            if (state == ST_INIT) begin
                tbl_wen = 1'b1;
                tbl_idx = init_cnt;
            end else begin
                forced       = q_deq_val && (q_full || starve_cnt == SC_W'(STARVE_LIM - 1));
                pred_req_rdy = !forced;
                upd_rdy      = q_enq_rdy;
                lookup       = pred_req_val && !forced;
                drain        = forced || (!lookup && q_deq_val);
                if (lookup) begin
                    tbl_idx = req_idx;
                end else if (drain) begin
                    tbl_wen = 1'b1;
                    tbl_idx = IDX_W'(deq_msg.idx);
                end
            end
        end
    end

    always_comb begin
        tbl_wdata = '0;
        if (state == ST_INIT) begin
            tbl_wdata = PHT_WEAK_NT;
        end else if (drain) begin
            tbl_wdata = sat_ctr_next(tbl_rdata, deq_msg.taken);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt        <= '0;
            starve_cnt      <= '0;
            pred_resp_val   <= 1'b0;
            pred_resp_taken <= 1'b0;
            init_done       <= 1'b0;
        end else begin
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
                if (init_cnt == IDX_W'(PHT_SIZE - 1)) begin
                    init_done <= 1'b1;
                end
            end
            pred_resp_val <= lookup;
            if (lookup) begin
                pred_resp_taken <= tbl_rdata[1];
            end
            if (drain || q_empty) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_pht_ctrl.sv
// Bench for branch_pht_ctrl: directed vector table, corner sequences and random traffic
// checked against a queue-based reference model of the PHT controller.
module tb_branch_pht_ctrl;

    localparam int unsigned N   = 16;
    localparam int unsigned IW  = 4;
    localparam int unsigned D   = 4;
    localparam int unsigned LIM = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          pred_req_val;
    logic          pred_req_rdy;
    logic [31:0]   pred_req_pc;
    logic          pred_resp_val;
    logic          pred_resp_taken;
    logic          upd_val;
    logic          upd_rdy;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [IW-1:0] tbl_idx;
    logic          tbl_wen;
    logic [1:0]    tbl_wdata;
    logic [1:0]    tbl_rdata;
    logic          init_done;

    branch_pht_ctrl #(
        .PHT_SIZE   (N),
        .IDX_W      (IW),
        .UPD_DEPTH  (D),
        .STARVE_LIM (LIM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pred_req_val    (pred_req_val),
        .pred_req_rdy    (pred_req_rdy),
        .pred_req_pc     (pred_req_pc),
        .pred_resp_val   (pred_resp_val),
        .pred_resp_taken (pred_resp_taken),
        .upd_val         (upd_val),
        .upd_rdy         (upd_rdy),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .tbl_idx         (tbl_idx),
        .tbl_wen         (tbl_wen),
        .tbl_wdata       (tbl_wdata),
        .tbl_rdata       (tbl_rdata),
        .init_done       (init_done)
    );

    always #5 clk = ~clk;

    // Behavioural single-port table the controller drives.
    logic [1:0] pht [N];
    assign tbl_rdata = pht[tbl_idx];
    always @(posedge clk) if (tbl_wen) pht[tbl_idx] <= tbl_wdata;

    typedef struct { int idx; bit taken; } mupd_t;
    mupd_t mq[$];
    bit    m_known = 0;
    bit    m_run, m_rv, m_rt, m_done;
    int    m_cnt, m_starve;
    int    mpht [N];

    int checks = 0;
    int errors = 0;

    bit o_rdy, o_urdy, o_wen, o_rv, o_rt, o_done;
    int o_idx, o_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit rv, input logic [31:0] rpc,
                        input bit uv, input logic [31:0] upc, input bit ut);
        bit e_rdy, e_urdy, e_wen, forced, lk, dr;
        int e_idx, e_wd, ridx, uidx, qsz, c;
        reset = rst; pred_req_val = rv; pred_req_pc = rpc;
        upd_val = uv; upd_pc = upc; upd_taken = ut;
        @(negedge clk);
        ridx = int'((rpc >> 2) % N);
        uidx = int'((upc >> 2) % N);
        qsz = mq.size();
        e_rdy = 0; e_urdy = 0; e_wen = 0; e_idx = 0; e_wd = 0; lk = 0; dr = 0; forced = 0;
        if (!rst) begin
            if (!m_run) begin
                e_wen = 1; e_idx = m_cnt; e_wd = 1;
            end else begin
                forced = qsz > 0 && (qsz == D || m_starve == LIM - 1);
                e_rdy  = !forced;
                e_urdy = qsz < D;
                lk = rv && !forced;
                dr = forced || (!lk && qsz > 0);
                if (lk) e_idx = ridx;
                else if (dr) begin
                    e_wen = 1;
                    e_idx = mq[0].idx;
                    c = mpht[mq[0].idx];
                    e_wd = mq[0].taken ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
                end
            end
        end
        o_rdy = pred_req_rdy; o_urdy = upd_rdy; o_wen = tbl_wen; o_idx = int'(tbl_idx);
        o_wd = int'(tbl_wdata); o_rv = pred_resp_val; o_rt = pred_resp_taken; o_done = init_done;
        chk("pred_req_rdy", pred_req_rdy, e_rdy);
        chk("upd_rdy", upd_rdy, e_urdy);
        chk("tbl_wen", tbl_wen, e_wen);
        chk("tbl_idx", tbl_idx, e_idx);
        if (e_wen) chk("tbl_wdata", tbl_wdata, e_wd);
        if (m_known) begin
            chk("pred_resp_val", pred_resp_val, m_rv);
            chk("pred_resp_taken", pred_resp_taken, m_rt);
            chk("init_done", init_done, m_done);
        end
        @(posedge clk);
        if (rst) begin
            m_known = 1; m_run = 0; m_cnt = 0; m_starve = 0;
            m_rv = 0; m_rt = 0; m_done = 0; mq.delete();
        end else if (!m_run) begin
            mpht[m_cnt] = 1;
            if (m_cnt == N - 1) begin m_run = 1; m_done = 1; end
            m_cnt++;
            m_rv = 0;
        end else begin
            m_rv = lk;
            if (lk) m_rt = (mpht[ridx] >= 2);
            if (dr) begin
                mpht[e_idx] = e_wd;
                void'(mq.pop_front());
            end
            m_starve = (dr || qsz == 0) ? 0 : m_starve + 1;
            if (uv && e_urdy) mq.push_back('{uidx, ut});
        end
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    typedef struct { int rv, rpc, uv, upc, ut, wen, idx, wd, rdy, resp_v, resp_t; } vec_t;
    vec_t vecs [15];

    initial begin
        int n;
        for (int i = 0; i < N; i++) pht[i] = 2'b11;
        reset = 1; pred_req_val = 0; pred_req_pc = 0; upd_val = 0; upd_pc = 0; upd_taken = 0;

        //              rv  rpc uv upc ut  wen idx wd rdy rv rt
        vecs[0]  = '{1, 8, 0, 0, 0,  0, 2, 0, 1, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 0, 1, 8, 1,  0, 0, 0, 1, 0, 0};
        vecs[4]  = '{0, 0, 1, 8, 1,  1, 2, 2, 1, 0, 0};
        vecs[5]  = '{0, 0, 1, 8, 1,  1, 2, 3, 1, 0, 0};
        vecs[6]  = '{0, 0, 0, 0, 0,  1, 2, 3, 1, 0, 0};
        vecs[7]  = '{1, 8, 0, 0, 0,  0, 2, 0, 1, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 1, 1};
        vecs[9]  = '{0, 0, 1, 8, 0,  0, 0, 0, 1, 0, 1};
        vecs[10] = '{0, 0, 1, 8, 0,  1, 2, 2, 1, 0, 1};
        vecs[11] = '{0, 0, 1, 8, 0,  1, 2, 1, 1, 0, 1};
        vecs[12] = '{0, 0, 1, 8, 0,  1, 2, 0, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 1};
        vecs[14] = '{0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1};

        // Reset then full initialization sweep.
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < N; i++) begin
            step(0, 0, 0, 1, 0, 1);
            chk("init_idx", o_idx, i);
            chk("init_done_low", o_done, 0);
        end
        idle();
        chk("init_done_high", o_done, 1);

        foreach (vecs[i]) begin
            step(0, vecs[i].rv[0], vecs[i].rpc, vecs[i].uv[0], vecs[i].upc, vecs[i].ut[0]);
            chk("vec_wen", o_wen, vecs[i].wen);
            chk("vec_idx", o_idx, vecs[i].idx);
            if (vecs[i].wen != 0) chk("vec_wdata", o_wd, vecs[i].wd);
            chk("vec_rdy", o_rdy, vecs[i].rdy);
            chk("vec_resp_val", o_rv, vecs[i].resp_v);
            chk("vec_resp_taken", o_rt, vecs[i].resp_t);
        end

        // Starvation bound with continuous lookups.
        step(0, 1, 32'h40, 1, 32'h10, 1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 32'h40, 0, 0, 0);
            if (!o_rdy) break;
            n++;
        end
        chk("starve_lookups", n, LIM - 1);
        chk("starve_drain_idx", o_idx, 4);
        step(0, 1, 32'h40, 0, 0, 0);
        chk("starve_resume", o_rdy, 1);

        // Fill the FIFO under continuous lookups.
        for (int k = 0; k < D; k++) begin
            step(0, 1, 32'h44, 1, 32'h20 + 4 * k, k[0]);
            chk("fill_urdy", o_urdy, 1);
        end
        step(0, 1, 32'h44, 0, 0, 0);
        chk("full_urdy", o_urdy, 0);
        chk("full_rdy", o_rdy, 0);
        chk("full_drain_wen", o_wen, 1);
        step(0, 1, 32'h44, 0, 0, 0);
        chk("reopen_urdy", o_urdy, 1);
        chk("reopen_rdy", o_rdy, 1);

        // Reset with updates still queued.
        step(1, 1, 32'h44, 0, 0, 0);
        chk("rst_no_write", o_wen, 0);
        for (int i = 0; i < N; i++) begin
            step(0, 1, 32'h44, 0, 0, 0);
            chk("reinit_idx", o_idx, i);
        end
        for (int i = 0; i < N; i++) chk("reinit_pht", pht[i], 1);
        for (int i = 0; i < N; i++) step(0, 1, 4 * i, 0, 0, 0);
        idle();

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            step($urandom_range(0, 499) == 0, $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_pht_ctrl.md
Name: branch_pht_ctrl

Overview:
Controller for a single-ported 2-bit pattern history table (PHT) shared by the fetch-stage prediction lookup and the resolved-branch update stream. After reset it initializes every PHT entry to weakly-not-taken. It then arbitrates the table port each cycle between lookups and buffered updates. Updates are queued in a small FIFO, so execute-stage resolution never stalls on lookup traffic. Lookups cannot starve updates.

Parameters:
PHT_SIZE, 2048, number of PHT entries (power of 2)
IDX_W, $clog2(PHT_SIZE), PHT index width
UPD_DEPTH, 4, update FIFO entries (power of 2, >=2)
STARVE_LIM, 8, max consecutive cycles a non-empty FIFO may go undrained

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
pred_req_val  in  1  lookup request valid
pred_req_rdy  out  1  lookup request accepted this cycle
pred_req_pc  in  32  lookup PC
pred_resp_val  out  1  prediction valid (one cycle pulse)
pred_resp_taken  out  1  predicted direction
upd_val  in  1  resolved-branch update valid
upd_rdy  out  1  update FIFO can accept
upd_pc  in  32  resolved branch PC
upd_taken  in  1  resolved direction
tbl_idx  out  IDX_W  PHT port index
tbl_wen  out  1  PHT write enable
tbl_wdata  out  2  PHT write data
tbl_rdata  in  2  PHT combinational read data at tbl_idx
init_done  out  1  high once initialization is complete

Behaviour:
- Index mapping: idx = pc[IDX_W+1:2], for both lookup and update.
- Reset (synchronous, any state, including mid-init or mid-drain):
  - state <= INIT, init_cnt <= 0, FIFO emptied, starve_cnt <= 0.
  - pred_resp_val <= 0, pred_resp_taken <= 0, init_done <= 0.
  - Queued updates are discarded.
- INIT state:
  - tbl_wen=1, tbl_idx=init_cnt, tbl_wdata=2'b01.
  - init_cnt increments each cycle.
  - On the cycle with init_cnt==PHT_SIZE-1, next state is RUN and init_done <= 1.
  - Init takes exactly PHT_SIZE cycles.
  - pred_req_rdy=0 and upd_rdy=0 throughout.
- RUN state, one port use per cycle, chosen in priority order:
  1. Drain: taken if FIFO full OR starve_cnt==STARVE_LIM-1 (with FIFO non-empty). pred_req_rdy=0.
  2. Lookup: taken if pred_req_val and not drain. pred_req_rdy=1, tbl_wen=0, tbl_idx=lookup idx.
  3. Drain: taken if FIFO non-empty and no lookup.
  4. Otherwise the port is idle: tbl_wen=0, tbl_idx=0.
- pred_req_rdy is combinational and must not depend on pred_req_val.
- Drain (single-cycle read-modify-write):
  - tbl_idx=head.idx, tbl_wen=1, FIFO head popped.
  - tbl_wdata = saturating update of tbl_rdata: taken -> min(rdata+1, 3); not-taken -> max(rdata-1, 0).
- Lookup response:
  - pred_resp_val <= lookup fire.
  - pred_resp_taken <= tbl_rdata[1] when fire, else holds its value.
  - Latency is 1 cycle, with no response backpressure.
- starve_cnt:
  - Cleared on drain or when the FIFO is empty.
  - Otherwise incremented each cycle the FIFO is non-empty and undrained.
  - Width is $clog2(STARVE_LIM)+1.
- Update FIFO:
  - upd_rdy = RUN && !full. A full FIFO does not accept, even if it drains in the same cycle.
  - Enqueue and dequeue in the same cycle is legal; the count is unchanged.
  - Order is preserved (updates to the same index apply in arrival order).
  - Pointers wrap modulo UPD_DEPTH.
  - Each entry stores {idx, taken} only.
- Hazard: a lookup to an index with pending queued updates returns the pre-update table value. This is defined behaviour; there is no forwarding.
- States: INIT, RUN. INIT->RUN on the final init write. RUN->INIT only on reset.

Decomposition:
- Package branch_pkg:
  - typedef upd_msg_t {logic [IDX_W-1:0] idx; logic taken;}
  - constant PHT_WEAK_NT = 2'b01
  - function sat_ctr_next(ctr, taken)
  - function pc_to_idx(pc)
- One sub-module: branch_upd_queue, a UPD_DEPTH-entry FIFO of upd_msg_t.
  - Ports: enq val/rdy, deq val/rdy, full, empty.

Test Plan:
1. PHT_SIZE=16, assert reset 2 cycles, then release -> tbl_wen=1 for 16 cycles with tbl_idx 0..15 and wdata=01; init_done rises after cycle 16; pred_req_rdy=upd_rdy=0 during init.
2. After init, lookup pc=0x0000_0008 -> tbl_idx=2 that cycle; next cycle pred_resp_val=1, taken=0; following cycle pred_resp_val=0.
3. Three taken updates for pc=0x8, no lookups -> three drains writing 10, 11, 11 (saturated); a subsequent lookup returns taken=1. Then four not-taken updates -> writes 10, 01, 00, 00.
4. pred_req_val held high, one update enqueued, STARVE_LIM=8 -> lookups accepted for 7 cycles; on the 8th cycle pred_req_rdy=0 and the update drains; lookups resume the next cycle.
5. UPD_DEPTH=4, lookups continuous, 4 updates enqueued back-to-back -> upd_rdy=0 after the 4th; pred_req_rdy=0 while full; each drain reopens upd_rdy the following cycle.
6. Reset asserted with 3 updates queued -> no drain writes occur; INIT restarts at tbl_idx=0; after init, the table reflects only 01 values.
